// File: rtl/exec_alu_mc_if.sv
// rtl/exec_alu_mc_if.sv - issue/result handshake bundle for the multi-cycle ALU
interface exec_alu_mc_if;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  ctrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [4:0]  shamt_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        illegal_o;

    modport master (
        output valid_i, ctrl_i, src1_i, src2_i, shamt_i, ready_i,
        input  ready_o, valid_o, result_o, zero_o, illegal_o
    );

    modport slave (
        input  valid_i, ctrl_i, src1_i, src2_i, shamt_i, ready_i,
        output ready_o, valid_o, result_o, zero_o, illegal_o
    );
endinterface

// File: rtl/exec_alu_mc.sv
// rtl/exec_alu_mc.sv - ALU with registered result and optional iterative multiply (ALU_MUL_EN)
module exec_alu_mc (
    input  logic         clk_i,
    input  logic         rst_i,
    exec_alu_mc_if.slave bus
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SRAV = 4'b1001;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1011;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef ALU_MUL_EN
        ST_MUL  = 2'd1,
`endif
        ST_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d, start_state;
    logic        ready, valid, accept;
    logic [31:0] alu_res;
    logic        alu_ill;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        illegal_q, illegal_d;

`ifdef ALU_MUL_EN
    logic        is_mul;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] acc_next;
    logic [4:0]  cnt_q, cnt_d;

    assign is_mul      = (bus.ctrl_i == OP_MUL);
    assign start_state = is_mul ? ST_MUL : ST_DONE;
    assign acc_next    = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
`else
    assign start_state = ST_DONE;
`endif

    assign accept = bus.valid_i && ready;

    // Single-cycle datapath; unsupported codes yield zero and flag illegal.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (bus.ctrl_i)
            OP_AND:  alu_res = bus.src1_i & bus.src2_i;
            OP_OR:   alu_res = bus.src1_i | bus.src2_i;
            OP_ADD:  alu_res = bus.src1_i + bus.src2_i;
            OP_SUB:  alu_res = bus.src1_i - bus.src2_i;
            OP_SLT:  alu_res = {31'd0, $signed(bus.src1_i) < $signed(bus.src2_i)};
            OP_SRA:  alu_res = $signed(bus.src2_i) >>> bus.shamt_i;
            OP_SRAV: alu_res = $signed(bus.src2_i) >>> bus.src1_i[4:0];
            default: begin
                alu_res = '0;
                alu_ill = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.valid_i) state_d = start_state;
`ifdef ALU_MUL_EN
            ST_MUL:  if (cnt_q == 5'd31) state_d = ST_DONE;
`endif
            ST_DONE: if (bus.ready_i) state_d = bus.valid_i ? start_state : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        valid = 1'b0;
        case (state_q)
            ST_IDLE: ready = 1'b1;
            ST_DONE: begin
                ready = bus.ready_i;
                valid = 1'b1;
            end
            default: begin
                ready = 1'b0;
                valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifdef ALU_MUL_EN
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
`endif
        if (accept) begin
`ifdef ALU_MUL_EN
            if (is_mul) begin
                mcand_d  = bus.src1_i;
                mplier_d = bus.src2_i;
                acc_d    = '0;
                cnt_d    = '0;
            end else
`endif
            begin
                result_d  = alu_res;
                zero_d    = (alu_res == 32'd0);
                illegal_d = alu_ill;
            end
        end
`ifdef ALU_MUL_EN
        // One multiplier bit per cycle; the low 32 product bits are sign-agnostic.
        else if (state_q == ST_MUL) begin
            acc_d    = acc_next;
            mcand_d  = {mcand_q[30:0], 1'b0};
            mplier_d = {1'b0, mplier_q[31:1]};
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                result_d  = acc_next;
                zero_d    = (acc_next == 32'd0);
                illegal_d = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
`ifdef ALU_MUL_EN
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.ready_o   = ready;
    assign bus.valid_o   = valid;
    assign bus.result_o  = result_q;
    assign bus.zero_o    = zero_q;
    assign bus.illegal_o = illegal_q;

endmodule

// File: tb/tb_exec_alu_mc.sv
// tb/tb_exec_alu_mc.sv - directed self-checking bench for exec_alu_mc
module tb_exec_alu_mc;

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_SRA  = 4'b1000;
    localparam logic [3:0] C_SRAV = 4'b1001;
    localparam logic [3:0] C_MUL  = 4'b1011;
    localparam logic [3:0] C_BAD  = 4'b0011;

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    exec_alu_mc_if bus();

    exec_alu_mc dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic rdy);
        bus.valid_i = v;
        bus.ctrl_i  = c;
        bus.src1_i  = a;
        bus.src2_i  = b;
        bus.shamt_i = sh;
        bus.ready_i = rdy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, C_ADD, 32'd1, 32'd1, 5'd0, 1'b1);
        tick();
        tick();
        checks++; if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", bus.valid_o); end
        checks++; if (bus.result_o !== 32'd0) begin fails++; $display("FAIL rst_result got=%h exp=0", bus.result_o); end
        checks++; if (bus.zero_o !== 1'b0) begin fails++; $display("FAIL rst_zero got=%b exp=0", bus.zero_o); end
        checks++; if (bus.illegal_o !== 1'b0) begin fails++; $display("FAIL rst_illegal got=%b exp=0", bus.illegal_o); end
        rst = 1'b0;
        drive(1'b0, C_ADD, 32'd0, 32'd0, 5'd0, 1'b1);
        checks++; if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL rst_ready got=%b exp=1", bus.ready_o); end
        tick();
        checks++; if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL rst_priority got=%b exp=0", bus.valid_o); end
    endtask

    task automatic test_add();
        drive(1'b1, C_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b1);
        tick();
        drive(1'b0, C_ADD, 32'd0, 32'd0, 5'd0, 1'b1);
        checks++; if (bus.valid_o !== 1'b1) begin fails++; $display("FAIL add_valid got=%b exp=1", bus.valid_o); end
        checks++; if (bus.result_o !== 32'h8000_0000) begin fails++; $display("FAIL add_result got=%h exp=80000000", bus.result_o); end
        checks++; if (bus.zero_o !== 1'b0 || bus.illegal_o !== 1'b0) begin fails++; $display("FAIL add_flags got=%b%b exp=00", bus.zero_o, bus.illegal_o); end
        tick();
        checks++; if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL add_idle got=%b exp=0", bus.valid_o); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, C_SUB, 32'd5, 32'd5, 5'd0, 1'b1);
        tick();
        checks++; if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd0 || bus.zero_o !== 1'b1) begin fails++; $display("FAIL b2b_sub got=%b/%h/%b exp=1/0/1", bus.valid_o, bus.result_o, bus.zero_o); end
        checks++; if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL b2b_ready got=%b exp=1", bus.ready_o); end
        drive(1'b1, C_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1);
        tick();
        drive(1'b0, C_ADD, 32'd0, 32'd0, 5'd0, 1'b1);
        checks++; if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd1 || bus.zero_o !== 1'b0) begin fails++; $display("FAIL b2b_slt got=%b/%h/%b exp=1/1/0", bus.valid_o, bus.result_o, bus.zero_o); end
        tick();
    endtask

    task automatic test_logic_shift();
        drive(1'b1, C_SRA, 32'h0000_0000, 32'h8000_0000, 5'd4, 1'b1);
        tick();
        checks++; if (bus.result_o !== 32'hF800_0000) begin fails++; $display("FAIL sra got=%h exp=f8000000", bus.result_o); end
        drive(1'b1, C_SRAV, 32'h0000_0024, 32'h8000_0000, 5'd0, 1'b1);
        tick();
        checks++; if (bus.result_o !== 32'hF800_0000) begin fails++; $display("FAIL srav got=%h exp=f8000000", bus.result_o); end
        drive(1'b1, C_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 1'b1);
        tick();
        checks++; if (bus.result_o !== 32'hF000_F000) begin fails++; $display("FAIL and got=%h exp=f000f000", bus.result_o); end
        drive(1'b1, C_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 1'b1);
        tick();
        checks++; if (bus.result_o !== 32'hFFF0_FFF0) begin fails++; $display("FAIL or got=%h exp=fff0fff0", bus.result_o); end
        drive(1'b1, C_BAD, 32'h1234_5678, 32'h1, 5'd0, 1'b1);
        tick();
        drive(1'b0, C_ADD, 32'd0, 32'd0, 5'd0, 1'b1);
        checks++; if (bus.result_o !== 32'd0 || bus.illegal_o !== 1'b1 || bus.zero_o !== 1'b1) begin fails++; $display("FAIL illegal got=%h/%b/%b exp=0/1/1", bus.result_o, bus.illegal_o, bus.zero_o); end
        tick();
    endtask

    task automatic test_mul();
        int bad;
        bad = 0;
        drive(1'b1, C_MUL, 32'hFFFF_FFFF, 32'd3, 5'd0, 1'b1);
        tick();
        drive(1'b0, C_ADD, 32'd0, 32'd0, 5'd0, 1'b1);
`ifdef ALU_MUL_EN
        for (int k = 0; k < 31; k++) begin
            if (bus.ready_o !== 1'b0 || bus.valid_o !== 1'b0) bad++;
            tick();
        end
        if (bus.ready_o !== 1'b0 || bus.valid_o !== 1'b0) bad++;
        checks++; if (bad != 0) begin fails++; $display("FAIL mul_busy got=%0d bad cycles exp=0", bad); end
        tick();
        checks++; if (bus.valid_o !== 1'b1 || bus.result_o !== 32'hFFFF_FFFD || bus.illegal_o !== 1'b0) begin fails++; $display("FAIL mul_result got=%b/%h/%b exp=1/fffffffd/0", bus.valid_o, bus.result_o, bus.illegal_o); end
`else
        checks++; if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd0 || bus.illegal_o !== 1'b1) begin fails++; $display("FAIL mul_illegal got=%b/%h/%b exp=1/0/1", bus.valid_o, bus.result_o, bus.illegal_o); end
        checks++; if (bad != 0) begin fails++; $display("FAIL mul_busy got=%0d exp=0", bad); end
`endif
        tick();
        checks++; if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL mul_idle got=%b exp=0", bus.valid_o); end
    endtask

    task automatic test_hold();
        int bad;
        bad = 0;
        drive(1'b1, C_ADD, 32'd3, 32'd4, 5'd0, 1'b0);
        tick();
        drive(1'b1, C_SUB, 32'd9, 32'd1, 5'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd7 || bus.zero_o !== 1'b0 ||
                bus.illegal_o !== 1'b0 || bus.ready_o !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin fails++; $display("FAIL hold_stable got=%0d bad cycles exp=0", bad); end
        checks++; if (bus.result_o !== 32'd7) begin fails++; $display("FAIL hold_ignore got=%h exp=7", bus.result_o); end
        drive(1'b0, C_ADD, 32'd0, 32'd0, 5'd0, 1'b1);
        tick();
        checks++; if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL hold_release got=%b exp=0", bus.valid_o); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
`ifdef ALU_MUL_EN
        drive(1'b1, C_MUL, 32'd7, 32'd9, 5'd0, 1'b1);
        tick();
        drive(1'b0, C_ADD, 32'd0, 32'd0, 5'd0, 1'b1);
        repeat (10) tick();
`else
        drive(1'b1, C_ADD, 32'd5, 32'd6, 5'd0, 1'b0);
        tick();
        drive(1'b0, C_ADD, 32'd0, 32'd0, 5'd0, 1'b0);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, C_ADD, 32'd0, 32'd0, 5'd0, 1'b1);
        checks++; if (bus.valid_o !== 1'b0 || bus.result_o !== 32'd0 || bus.zero_o !== 1'b0 || bus.illegal_o !== 1'b0) begin fails++; $display("FAIL midrst_out got=%b/%h/%b/%b exp=0/0/0/0", bus.valid_o, bus.result_o, bus.zero_o, bus.illegal_o); end
        checks++; if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL midrst_ready got=%b exp=1", bus.ready_o); end
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.valid_o !== 1'b0) pulses++;
        end
        checks++; if (pulses != 0) begin fails++; $display("FAIL midrst_pulse got=%0d exp=0", pulses); end
        drive(1'b1, C_ADD, 32'd2, 32'd2, 5'd0, 1'b1);
        tick();
        drive(1'b0, C_ADD, 32'd0, 32'd0, 5'd0, 1'b1);
        checks++; if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd4) begin fails++; $display("FAIL midrst_add got=%b/%h exp=1/4", bus.valid_o, bus.result_o); end
        tick();
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        drive(1'b0, C_AND, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
        test_reset();
        test_add();
        test_back_to_back();
        test_logic_shift();
        test_mul();
        test_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/exec_alu_mc.md
EXEC_ALU_MC -- requirements
Module: exec_alu_mc

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 clk_i  input  1  Clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  Synchronous reset, active-high.
REQ-004 valid_i  input  1  Operation request from the issue stage.
REQ-005 ready_o  output  1  Block can accept an operation this cycle.
REQ-006 ctrl_i  input  4  ALU control code from the ALU controller.
REQ-007 src1_i  input  32  Operand 1 (rs).
REQ-008 src2_i  input  32  Operand 2 (rt or immediate).
REQ-009 shamt_i  input  5  Shift amount for SRA.
REQ-010 valid_o  output  1  Result available.
REQ-011 ready_i  input  1  Downstream accepts the result.
REQ-012 result_o  output  32  Registered result.
REQ-013 zero_o  output  1  High when result_o == 0.
REQ-014 illegal_o  output  1  Completed operation had an unsupported ctrl_i.

Function
REQ-015 An operation SHALL be accepted on a rising edge where valid_i && ready_o; operands and ctrl_i are sampled only at acceptance.
REQ-016 The FSM SHALL have states IDLE, MUL, DONE.
REQ-017 ready_o SHALL be 1 in IDLE, 0 in MUL, and equal to ready_i in DONE (back-to-back issue).
REQ-018 Codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT signed (result 1/0), 1000 SRA = src2_i >>> shamt_i, 1001 SRAV = src2_i >>> src1_i[4:0], 1011 MUL.
REQ-019 ADD/SUB SHALL wrap modulo 2^32 with no overflow indication.
REQ-020 Single-cycle codes SHALL go from acceptance to DONE; valid_o is high in the cycle after acceptance.
REQ-021 MUL SHALL be an iterative shift-add over 32 cycles in state MUL, using a 5-bit counter that starts at 0; the transition to DONE occurs on the edge where the counter equals 31; valid_o is first high 32 cycles after acceptance.
REQ-022 MUL result SHALL be the low 32 bits of the unsigned product; this equals the signed product's low 32 bits.
REQ-023 Any other ctrl_i SHALL complete single-cycle with result_o = 0 and illegal_o = 1.
REQ-024 illegal_o SHALL be 0 for every supported code.
REQ-025 In DONE, valid_o SHALL be 1 and result_o, zero_o and illegal_o SHALL hold stable until ready_i = 1.
REQ-026 In DONE with ready_i = 1: if valid_i = 1 the new operation is accepted (next state per its code); otherwise the next state is IDLE.
REQ-027 valid_o SHALL be 0 in IDLE and MUL.
REQ-028 valid_i SHALL be ignored while ready_o = 0; no request is queued.

Reset
REQ-029 When rst_i = 1 at an edge, state SHALL become IDLE, and valid_o, result_o, zero_o and illegal_o SHALL be 0.
REQ-030 Reset during MUL or DONE SHALL discard the operation; no valid_o pulse follows.
REQ-031 Reset SHALL take priority over acceptance in the same cycle.
REQ-032 zero_o SHALL be 0 while in reset, although result_o = 0.

Configuration
REQ-033 The macro SHALL be ALU_MUL_EN.
REQ-034 With ALU_MUL_EN defined, code 1011 SHALL execute the iterative multiply of REQ-021.
REQ-035 Without ALU_MUL_EN, code 1011 SHALL be treated as illegal (REQ-023); the MUL state and multiplier logic are absent, and every operation is single-cycle.

Verification
REQ-036 ADD with src1 = 0x7FFFFFFF, src2 = 1, ready_i = 1 -> valid_o one cycle later; result 0x80000000; zero_o 0.
REQ-037 SUB 5-5, then SLT with -1 vs 1, issued back-to-back -> results 0 (zero_o 1), then 1, on consecutive cycles with no bubble.
REQ-038 SRA with src2 = 0x80000000, shamt = 4 -> 0xF8000000; SRAV with src1 = 0x24 (low 5 bits = 4), same src2 -> 0xF8000000.
REQ-039 MUL 0xFFFFFFFF × 3 with ALU_MUL_EN -> ready_o low for 32 cycles; valid_o at acceptance+32; result 0xFFFFFFFD. Without the macro -> illegal_o 1, result 0, one cycle.
REQ-040 Hold ready_i = 0 for 5 cycles in DONE -> result, valid_o and flags stable; valid_i is ignored.
REQ-041 Assert rst_i at MUL cycle 10 -> IDLE next edge; outputs 0; no valid_o; a new ADD is then accepted normally.
